// File: rtl/fp2int_sched.sv
// fp2int_sched: two-requester round-robin converter from IEEE-754 single to a 128-bit
// truncated integer magnitude, shifting the mantissa one bit per cycle.
module fp2int_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [31:0]  a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [31:0]  b_data,
  output logic         b_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_int,
  output logic         out_neg,
  output logic         out_src,
  output logic         out_ovf
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q;
  logic           ptr_q;
  logic           left_q;
  logic [6:0]     cnt_q;
  logic [127:0]   int_q;
  logic           vld_q;
  logic           neg_q;
  logic           src_q;
  logic           ovf_q;

  logic           idle;
  logic           grant_a;
  logic           grant_b;
  logic           accept;
  logic [31:0]    sel_data;
  logic [7:0]     exp_f;
  logic [6:0]     e_unb;
  logic [6:0]     cnt_w;
  logic [23:0]    mant;

  always_comb begin
    idle     = (state_q == IDLE);
    grant_a  = idle && (ptr_q ? (a_valid && !b_valid) : a_valid);
    grant_b  = idle && (ptr_q ? b_valid : (b_valid && !a_valid));
    accept   = grant_a || grant_b;
    sel_data = grant_b ? b_data : a_data;
    exp_f    = sel_data[30:23];
    mant     = {exp_f != 8'd0, sel_data[22:0]};
    // E-127 modulo 128 equals E+1 modulo 128; only meaningful when 127 <= E <= 254.
    e_unb    = exp_f[6:0] + 7'd1;
    cnt_w    = (e_unb > 7'd23) ? (e_unb - 7'd23) : (7'd23 - e_unb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      left_q  <= 1'b0;
      cnt_q   <= '0;
      int_q   <= '0;
      vld_q   <= 1'b0;
      neg_q   <= 1'b0;
      src_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ptr_q  <= grant_a;
            src_q  <= grant_b;
            neg_q  <= sel_data[31];
            ovf_q  <= 1'b0;
            int_q  <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
            if (exp_f == 8'd255) begin
              ovf_q   <= 1'b1;
              vld_q   <= 1'b1;
              state_q <= DONE;
            end else if (exp_f < 8'd127) begin
              vld_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              int_q  <= {104'd0, mant};
              left_q <= (e_unb > 7'd23);
              if (e_unb == 7'd23) begin
                vld_q   <= 1'b1;
                state_q <= DONE;
              end else begin
                cnt_q   <= cnt_w;
                state_q <= SHIFT;
              end
            end
          end
        end
        SHIFT: begin
          int_q <= left_q ? (int_q << 1) : (int_q >> 1);
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign out_valid = vld_q;
  assign out_int   = int_q;
  assign out_neg   = neg_q;
  assign out_src   = src_q;
  assign out_ovf   = ovf_q;
endmodule
